// File: rtl/wishbone_pkg.sv
// Shared types and defaults for the Wishbone-to-local-bus slave bridge.
package wishbone_pkg;

  localparam int WB_TAGSIZE = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    ACK   = 3'd2,
    ERR   = 3'd3,
    DRAIN = 3'd4
  } wb_state_e;

endpackage

// File: rtl/wishbone_slave.sv
// Wishbone slave that forwards decoded accesses to a simple local request/response port,
// with a response timeout and master-abort draining.
module wishbone_slave
  import wishbone_pkg::*;
#(
  parameter int          TAGSIZE   = WB_TAGSIZE,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [TAGSIZE-1:0] wb_tgd_i,
  input  logic [TAGSIZE-1:0] wb_tga_i,
  input  logic [TAGSIZE-1:0] wb_tgc_i,
  output logic [31:0]        wb_dat_o,
  output logic [TAGSIZE-1:0] wb_tgd_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  output logic [31:0]        addr_o,
  output logic [31:0]        data_o,
  output logic [3:0]         we_o,
  output logic               valid_o,
  input  logic [31:0]        data_i,
  input  logic               valid_i
);

  localparam int                CNT_W   = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

  wb_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             hit;
  logic             req;
  logic             timed_out;
  logic             unused_tags;

  function automatic logic addr_hit(input logic [31:0] adr);
    return ((adr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
  endfunction

  assign hit         = addr_hit(wb_adr_i);
  assign req         = wb_cyc_i && wb_stb_i;
  assign timed_out   = (cnt == CNT_MAX);
  assign wb_tgd_o    = '0;
  assign wb_rty_o    = 1'b0;
  assign unused_tags = ^{wb_tgd_i, wb_tga_i, wb_tgc_i};

  // ack/err are set on entry to ACK/ERR and cleared every other cycle, so each is a one-cycle pulse
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_o   <= '0;
      data_o   <= '0;
      we_o     <= '0;
      valid_o  <= 1'b0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (!hit) begin
              state    <= ERR;
              wb_err_o <= 1'b1;
            end else if (wb_we_i && (wb_sel_i == 4'b0000)) begin
              state    <= ACK;
              wb_ack_o <= 1'b1;
            end else begin
              addr_o  <= wb_adr_i;
              data_o  <= wb_dat_i;
              we_o    <= wb_we_i ? wb_sel_i : 4'b0000;
              valid_o <= 1'b1;
              cnt     <= '0;
              state   <= WAIT;
            end
          end
        end

        WAIT: begin
          // Master abort: the local side still owes a response, so keep the request up and drain it
          if (!wb_cyc_i) begin
            if (valid_i || timed_out) begin
              valid_o <= 1'b0;
              state   <= IDLE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= DRAIN;
            end
          end else if (valid_i) begin
            if (we_o == 4'b0000) begin
              wb_dat_o <= data_i;
            end
            valid_o  <= 1'b0;
            wb_ack_o <= 1'b1;
            state    <= ACK;
          end else if (timed_out) begin
            valid_o  <= 1'b0;
            wb_err_o <= 1'b1;
            state    <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DRAIN: begin
          if (valid_i || timed_out) begin
            valid_o <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ACK, ERR: begin
          state <= IDLE;
        end

        default: begin
          valid_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_slave.sv
// Directed bench for wishbone_slave: a scoreboard queue holds the expected bus response of each access.
module tb_wishbone_slave;
  import wishbone_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [1:0]  wb_tgd_i, wb_tga_i, wb_tgc_i;
  logic [31:0] wb_dat_o;
  logic [1:0]  wb_tgd_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o;
  logic [31:0] addr_o, data_o;
  logic [3:0]  we_o;
  logic        valid_o;
  logic [31:0] data_i;
  logic        valid_i;

  typedef struct {
    bit          is_err;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_cnt  = 0;

  wishbone_slave #(
    .TAGSIZE  (2),
    .BASE_ADDR(32'h0000_0000),
    .ADDR_MASK(32'hFFFF_0000),
    .TIMEOUT  (16)
  ) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_we_i (wb_we_i),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i),
    .wb_tgd_i(wb_tgd_i),
    .wb_tga_i(wb_tga_i),
    .wb_tgc_i(wb_tgc_i),
    .wb_dat_o(wb_dat_o),
    .wb_tgd_o(wb_tgd_o),
    .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o),
    .wb_rty_o(wb_rty_o),
    .addr_o  (addr_o),
    .data_o  (data_o),
    .we_o    (we_o),
    .valid_o (valid_o),
    .data_i  (data_i),
    .valid_i (valid_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk_i);
    cyc_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
  endtask

  task automatic release_bus();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  // Waits (bounded) for ack or err, then pops and compares the scoreboard entry.
  task automatic wait_resp(input string tag, input int budget);
    exp_t e;
    int   n = 0;
    while (!(wb_ack_o || wb_err_o) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_resp_seen"}, 32'(wb_ack_o | wb_err_o), 32'd1);
    check({tag, "_sb_entry"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_kind"}, {30'd0, wb_err_o, wb_ack_o}, e.is_err ? 32'd2 : 32'd1);
      if (!e.is_err) check({tag, "_dat"}, wb_dat_o, e.dat);
    end
  endtask

  // Releases the bus after a response and confirms the pulse lasted one cycle.
  task automatic finish_txn(input string tag);
    release_bus();
    tick();
    check({tag, "_pulse_end"}, {30'd0, wb_err_o, wb_ack_o}, 32'd0);
    check({tag, "_valid_low"}, 32'(valid_o), 32'd0);
  endtask

  // Full read; the local response arrives on WAIT cycle number wait_cyc.
  task automatic read_txn(input string tag, input logic [31:0] adr, input logic [31:0] rdat,
                          input int wait_cyc);
    drive(1'b0, adr, 32'h0, 4'hF);
    sb.push_back('{is_err: 1'b0, dat: rdat});
    tick();
    check({tag, "_valid"}, 32'(valid_o), 32'd1);
    check({tag, "_addr"}, addr_o, adr);
    check({tag, "_we"}, 32'(we_o), 32'd0);
    for (int i = 1; i < wait_cyc; i++) tick();
    check({tag, "_addr_stable"}, addr_o, adr);
    valid_i = 1'b1;
    data_i  = rdat;
    tick();
    valid_i = 1'b0;
    data_i  = 32'h0;
    wait_resp(tag, 8);
    finish_txn(tag);
  endtask

  initial begin
    int          start;
    int          vcount;
    logic        seen;
    rstn_i   = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = '0;
    wb_tgd_i = 2'b11;
    wb_tga_i = 2'b10;
    wb_tgc_i = 2'b01;
    data_i   = '0;
    valid_i  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ack_err", {30'd0, wb_err_o, wb_ack_o}, 32'd0);
    check("rst_addr", addr_o, 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_rty_tgd", {29'd0, wb_rty_o, wb_tgd_o}, 32'd0);
    rstn_i = 1'b1;
    tick();

    // Read with response on the third WAIT cycle
    read_txn("rd1", 32'h0000_0010, 32'hDEAD_BEEF, 3);

    // Write with immediate local response; ack sampled two cycles after the strobe
    drive(1'b1, 32'h0000_0004, 32'h1234_5678, 4'b0011);
    sb.push_back('{is_err: 1'b0, dat: 32'hDEAD_BEEF});
    start = cyc_cnt;
    tick();
    check("wr_we", 32'(we_o), 32'h3);
    check("wr_data", data_o, 32'h1234_5678);
    check("wr_addr", addr_o, 32'h4);
    valid_i = 1'b1;
    data_i  = 32'h5555_AAAA;
    tick();
    valid_i = 1'b0;
    wait_resp("wr", 8);
    check("wr_latency", 32'(cyc_cnt - start), 32'd2);
    finish_txn("wr");

    // Write with no byte lanes acks without a local request
    drive(1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'b0000);
    sb.push_back('{is_err: 1'b0, dat: 32'hDEAD_BEEF});
    tick();
    check("wr0_valid", 32'(valid_o), 32'd0);
    wait_resp("wr0", 4);
    finish_txn("wr0");

    // Decode miss
    drive(1'b0, 32'h0001_0000, 32'h0, 4'hF);
    sb.push_back('{is_err: 1'b1, dat: 32'h0});
    tick();
    check("miss_valid", 32'(valid_o), 32'd0);
    wait_resp("miss", 4);
    finish_txn("miss");

    // Timeout: valid_o high for TIMEOUT cycles, then err
    drive(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    sb.push_back('{is_err: 1'b1, dat: 32'h0});
    tick();
    vcount = 0;
    seen   = 1'b0;
    while (valid_o && vcount < 40) begin
      seen |= wb_ack_o | wb_err_o;
      vcount++;
      tick();
    end
    check("to_valid_cycles", 32'(vcount), 32'd16);
    check("to_no_early_resp", 32'(seen), 32'd0);
    wait_resp("to", 4);
    finish_txn("to");

    // Master abort in WAIT, local response five cycles later
    drive(1'b0, 32'h0000_0030, 32'h0, 4'hF);
    tick();
    release_bus();
    tick();
    check("ab_valid_held", 32'(valid_o), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= wb_ack_o | wb_err_o;
      tick();
    end
    valid_i = 1'b1;
    data_i  = 32'h0BAD_0BAD;
    tick();
    valid_i = 1'b0;
    seen |= wb_ack_o | wb_err_o;
    check("ab_no_resp", 32'(seen), 32'd0);
    check("ab_valid_drop", 32'(valid_o), 32'd0);
    check("ab_dat_kept", wb_dat_o, 32'hDEAD_BEEF);
    read_txn("rd2", 32'h0000_0040, 32'hCAFE_F00D, 1);

    // Asynchronous reset in WAIT; late local response ignored
    drive(1'b0, 32'h0000_0050, 32'h0, 4'hF);
    tick();
    check("rs_valid_pre", 32'(valid_o), 32'd1);
    #2 rstn_i = 1'b0;
    #1 check("rs_valid_async", 32'(valid_o), 32'd0);
    release_bus();
    tick();
    valid_i = 1'b1;
    data_i  = 32'h7777_7777;
    tick();
    rstn_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    check("rs_quiet", {29'd0, valid_o, wb_err_o, wb_ack_o}, 32'd0);
    check("rs_dat_cleared", wb_dat_o, 32'd0);
    read_txn("rd3", 32'h0000_0060, 32'h1357_9BDF, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wishbone_slave.md
WISHBONE_SLAVE -- requirements
Module: wishbone_slave

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- TAGSIZE, 2, width of all Wishbone tag signals.
- BASE_ADDR, 32'h0000_0000, decoded base address.
- ADDR_MASK, 32'hFFFF_0000, address bits compared against BASE_ADDR.
- TIMEOUT, 16, maximum cycles allowed for a local response.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning); one clock; reset is asynchronous and active-low:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- wb_cyc_i  in  1  cycle in progress.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  32  address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte select.
- wb_tgd_i, wb_tga_i, wb_tgc_i  in  TAGSIZE  tags (ignored).
- wb_dat_o  out  32  read data.
- wb_tgd_o  out  TAGSIZE  data tag, constant 0.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  error.
- wb_rty_o  out  1  retry, constant 0.
- addr_o  out  32  local address.
- data_o  out  32  local write data.
- we_o  out  4  local byte write enables; 0 means read.
- valid_o  out  1  local request pending.
- data_i  in  32  local read data.
- valid_i  in  1  local response, one-cycle pulse.

Function
REQ-003 States SHALL be IDLE, WAIT, ACK, ERR and DRAIN.
REQ-004 Address decode SHALL be hit = ((wb_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)).
REQ-005 IDLE, with cyc&stb&!hit: go to ERR; no local request is issued.
REQ-006 IDLE, with cyc&stb&hit&we&(sel==0): go to ACK directly; no local request is issued.
REQ-007 IDLE, otherwise on cyc&stb&hit: register adr, dat and sel into addr_o, data_o and we_o (we_o = we ? sel : 4'b0); assert valid_o; clear the timeout counter; go to WAIT.
REQ-008 In WAIT, valid_o SHALL stay high and addr_o, data_o and we_o SHALL stay stable.
REQ-009 WAIT with valid_i: capture data_i into the read register (reads only); deassert valid_o; go to ACK.
REQ-010 ACK SHALL drive wb_ack_o=1 for exactly one cycle with wb_dat_o = captured data, then go to IDLE; minimum latency is request cycle + 2 cycles to ack.
REQ-011 ERR SHALL drive wb_err_o=1 for exactly one cycle, then go to IDLE.
REQ-012 WAIT timeout: the counter increments each WAIT cycle without valid_i; reaching TIMEOUT-1 SHALL deassert valid_o and go to ERR. valid_i arriving in the same cycle wins.
REQ-013 WAIT with wb_cyc_i low (master abort): go to DRAIN with valid_o held; DRAIN waits for valid_i or timeout, then goes to IDLE; no ack or err is issued.
REQ-014 wb_ack_o and wb_err_o SHALL be registered, mutually exclusive, and never high outside ACK or ERR.
REQ-015 wb_dat_o SHALL hold the last captured read data between transactions; write transactions do not alter it.
REQ-016 A new strobe is sampled only in IDLE; strobes seen in ACK or ERR are ignored.

Reset
REQ-017 rstn_i low SHALL asynchronously force:
- state to IDLE;
- the timeout counter and all registers to 0;
- valid_o, wb_ack_o and wb_err_o to 0.
REQ-018 Reset mid-transaction SHALL drop valid_o immediately; an in-flight local response arriving after reset is ignored.

Structure
REQ-019 Package wishbone_pkg SHALL hold the slave state enum type and the default TAGSIZE constant; the timeout counter width SHALL be $clog2(TIMEOUT)+1.
REQ-020 The design SHALL be a single module with no sub-module; the counter is inline.

Verification
REQ-021 Read at 32'h0000_0010, local valid_i with data_i=32'hDEAD_BEEF on the 3rd WAIT cycle -> addr_o=32'h10, we_o=0; one-cycle wb_ack_o with wb_dat_o=32'hDEAD_BEEF.
REQ-022 Write adr 32'h0000_0004, dat 32'h1234_5678, sel 4'b0011, immediate valid_i -> we_o=4'b0011, data_o=32'h1234_5678; ack 2 cycles after stb sampled.
REQ-023 Access to 32'h0001_0000 -> one-cycle wb_err_o, valid_o never asserted.
REQ-024 Read with no valid_i, TIMEOUT=16 -> valid_o high for 16 cycles, then one-cycle wb_err_o, no ack.
REQ-025 Master drops cyc in WAIT, valid_i 5 cycles later -> no ack or err; back in IDLE; next read completes normally.
REQ-026 rstn_i low while in WAIT -> valid_o=0 asynchronously; state IDLE after release.
